// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold,
        StFlush
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding the read that was in flight when decode stalled.
module fetch_skid #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [31:0]       data,
    input  logic [ADDR_W-1:0] pc,
    output logic              valid,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            out_data <= '0;
            out_pc   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            out_data <= data;
            out_pc   <= pc;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: sequential fetch with 2-cycle latency, decode stall
// handling through a skid register, and branch redirect/flush from execute.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              global_disable,
    input  logic [31:0]       delta_instruction,
    input  logic              stall,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam logic [ADDR_W-1:0] PcInit = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(INSTR_BYTES);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] rd_pc_q;
    logic              rd_pending_q;
    logic              gd_q;
    logic              gd_rise;
    logic [ADDR_W-1:0] branch_off;

    logic              skid_valid;
    logic              skid_clear;
    logic              skid_load;
    logic [31:0]       skid_data;
    logic [ADDR_W-1:0] skid_pc;

    // Offset bits above the address width fall away under modulo-2^ADDR_W wrap.
    logic unused_delta_hi;
    assign unused_delta_hi = ^delta_instruction[31:ADDR_W-2];

    assign gd_rise    = global_disable & ~gd_q;
    assign branch_off = {delta_instruction[ADDR_W-3:0], 2'b00};

    assign imem_en   = ((state_q == StRun) || (state_q == StHold)) && !stall && !gd_rise;
    assign imem_addr = imem_en ? pc_q : '0;

    // A stalled output cannot take the arriving read, so it parks in the skid.
    assign skid_clear = gd_rise || (state_q == StFlush) || (!stall && skid_valid);
    assign skid_load  = !gd_rise && (state_q != StFlush) && stall && rd_pending_q;

    fetch_skid #(
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (skid_clear),
        .load    (skid_load),
        .data    (imem_rdata),
        .pc      (rd_pc_q),
        .valid   (skid_valid),
        .out_data(skid_data),
        .out_pc  (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= PcInit;
            rd_pc_q      <= '0;
            rd_pending_q <= 1'b0;
            gd_q         <= 1'b0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            instr_pc     <= '0;
        end else begin
            gd_q         <= global_disable;
            rd_pending_q <= imem_en;
            if (imem_en) begin
                rd_pc_q <= pc_q;
            end

            if (gd_rise) begin
                pc_q        <= pc_q + branch_off;
                state_q     <= StFlush;
                instr_valid <= 1'b0;
            end else begin
                if (imem_en) begin
                    pc_q <= pc_q + PcStep;
                end

                unique case (state_q)
                    StIdle:  state_q <= StRun;
                    StRun:   if (stall) state_q <= StHold;
                    StHold:  if (!stall) state_q <= StRun;
                    StFlush: if (!global_disable) state_q <= StRun;
                    default: state_q <= StIdle;
                endcase

                if (state_q == StFlush) begin
                    instr_valid <= 1'b0;
                end else if (!stall) begin
                    if (skid_valid) begin
                        instr       <= skid_data;
                        instr_pc    <= skid_pc;
                        instr_valid <= 1'b1;
                    end else if (rd_pending_q) begin
                        instr       <= imem_rdata;
                        instr_pc    <= rd_pc_q;
                        instr_valid <= 1'b1;
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized stall/branch
// traffic checked against a stream-level model of the fetch pc and issued addresses.
module tb_fetch;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          global_disable = 1'b0;
    logic [31:0]   delta_instruction = '0;
    logic          stall = 1'b0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = '0;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [AW-1:0] instr_pc;

    int checks = 0;
    int errors = 0;

    // Values sampled mid-cycle by tick().
    logic          s_valid;
    logic [31:0]   s_instr;
    logic [AW-1:0] s_pc;
    logic          s_en;
    logic [AW-1:0] s_addr;

    // Stream model: fetch pc plus addresses issued but not yet consumed.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] q_pc[$];
    int            q_cyc[$];
    bit            m_idle, m_flushing, m_gd_prev, m_prev_stall, m_prev_rise;
    int            m_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr[AW-1:2]);
    end

    fetch #(
        .ADDR_W  (AW),
        .RESET_PC(0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .global_disable   (global_disable),
        .delta_instruction(delta_instruction),
        .stall            (stall),
        .imem_en          (imem_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .instr_pc         (instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a[AW-1:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_cyc.delete();
        m_pc         = '0;
        m_idle       = 1'b1;
        m_flushing   = 1'b0;
        m_gd_prev    = 1'b0;
        m_prev_stall = 1'b1;
        m_prev_rise  = 1'b0;
        m_cyc        = 0;
    endtask

    task automatic do_reset();
        stall = 1'b0;
        global_disable = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, check and update the model.
    task automatic tick(input logic s, input logic g, input logic [31:0] d);
        bit rise, fetch_now;
        stall = s;
        global_disable = g;
        delta_instruction = d;
        @(negedge clk);
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_en    = imem_en;
        s_addr  = imem_addr;

        rise      = g && !m_gd_prev;
        fetch_now = !m_idle && !m_flushing && !s && !rise;
        chk("imem_en", 32'(s_en), 32'(fetch_now));
        if (fetch_now) chk("imem_addr", 32'(s_addr), 32'(m_pc));

        if (m_flushing) begin
            chk("flush_valid", 32'(s_valid), 32'd0);
        end else begin
            if (q_pc.size() > 0 && !m_prev_stall && !m_prev_rise && q_cyc[0] + 2 <= m_cyc)
                chk("stream_gap", 32'(s_valid), 32'd1);
            if (s_valid) begin
                checks++;
                assert (q_pc.size() > 0)
                else begin
                    errors++;
                    $error("FAIL stream_extra: got instr_pc %h, expected no instruction", s_pc);
                end
                if (q_pc.size() > 0) begin
                    chk("stream_pc", 32'(s_pc), 32'(q_pc[0]));
                    chk("stream_instr", s_instr, mem_word(q_pc[0]));
                    if (!s) begin
                        void'(q_pc.pop_front());
                        void'(q_cyc.pop_front());
                    end
                end
            end
        end

        if (rise) begin
            q_pc.delete();
            q_cyc.delete();
            m_pc = AW'(int'(m_pc) + 4 * $signed(d));
            m_flushing = 1'b1;
        end else begin
            if (fetch_now) begin
                q_pc.push_back(m_pc);
                q_cyc.push_back(m_cyc);
                m_pc = m_pc + AW'(4);
            end
            if (m_flushing && !g) m_flushing = 1'b0;
        end
        m_idle       = 1'b0;
        m_prev_stall = s;
        m_prev_rise  = rise;
        m_gd_prev    = g;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] e_instr, input logic [AW-1:0] e_pc);
        int n;
        n = 0;
        do begin
            tick(1'b0, 1'b0, 32'd0);
            n++;
        end while (!s_valid && n < 20);
        chk({tag, "_valid"}, 32'(s_valid), 32'd1);
        chk({tag, "_instr"}, s_instr, e_instr);
        chk({tag, "_pc"}, 32'(s_pc), 32'(e_pc));
    endtask

    initial begin
        int gd_left;
        #2;
        // Sequential fetch, latency and a 3-cycle stall.
        do_reset();
        tick(0, 0, 0);
        chk("idle_valid", 32'(s_valid), 32'd0);
        tick(0, 0, 0);
        chk("first_en", 32'(s_en), 32'd1);
        chk("first_addr", 32'(s_addr), 32'd0);
        tick(0, 0, 0);
        chk("fill_valid", 32'(s_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            chk("seq_valid", 32'(s_valid), 32'd1);
            chk("seq_instr", s_instr, 32'h1000_0000 + 32'(i));
            chk("seq_pc", 32'(s_pc), 32'(4 * i));
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            chk("hold_instr", s_instr, 32'h1000_0003);
            chk("hold_en", 32'(s_en), 32'd0);
        end
        tick(0, 0, 0);
        chk("release_instr", s_instr, 32'h1000_0003);
        tick(0, 0, 0);
        chk("skid_instr", s_instr, 32'h1000_0004);
        tick(0, 0, 0);
        chk("resume_instr", s_instr, 32'h1000_0005);

        // Branch +10 from pc 0x014, global_disable held 2 cycles.
        do_reset();
        repeat (6) tick(0, 0, 0);
        tick(0, 1, 32'd10);
        tick(0, 1, 32'd99);
        chk("flush1_valid", 32'(s_valid), 32'd0);
        tick(0, 0, 0);
        chk("flush2_valid", 32'(s_valid), 32'd0);
        tick(0, 0, 0);
        chk("target_addr", 32'(s_addr), 32'h03C);
        wait_valid("br_fwd", 32'h1000_000F, 10'h03C);

        // Branch -4 from pc 0x008, then wrap past 0x3FC.
        do_reset();
        repeat (3) tick(0, 0, 0);
        tick(0, 1, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("neg_addr", 32'(s_addr), 32'h3F8);
        wait_valid("br_neg", 32'h1000_00FE, 10'h3F8);
        wait_valid("wrap_a", 32'h1000_00FF, 10'h3FC);
        wait_valid("wrap_b", 32'h1000_0000, 10'h000);

        // Branch rising together with stall.
        do_reset();
        repeat (5) tick(0, 0, 0);
        tick(1, 1, 32'd2);
        tick(1, 0, 0);
        chk("st_flush_valid", 32'(s_valid), 32'd0);
        tick(1, 0, 0);
        chk("st_hold_en", 32'(s_en), 32'd0);
        tick(0, 0, 0);
        chk("st_target", 32'(s_addr), 32'h018);
        wait_valid("br_stall", 32'h1000_0006, 10'h018);

        // Reset pulse mid-stream.
        do_reset();
        repeat (8) tick(0, 0, 0);
        chk("pre_rst_valid", 32'(s_valid), 32'd1);
        #2;
        do_reset();
        wait_valid("restart", 32'h1000_0000, 10'h000);

        // Random stall and branch traffic.
        do_reset();
        gd_left = 0;
        for (int i = 0; i < 800; i++) begin
            logic s, g;
            int   d;
            s = ($urandom_range(0, 3) == 0);
            d = int'($urandom_range(0, 16)) - 8;
            if (gd_left > 0) begin
                g = 1'b1;
                gd_left--;
            end else begin
                g = 1'b0;
                if ($urandom_range(0, 24) == 0) gd_left = int'($urandom_range(1, 3));
            end
            tick(s, g, 32'(d));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
